rle_decoder: RTL and testbench
==============================

// Module: rle_decoder
// PURPOSE
//  Inverse of the fabric RLE encoder. Reads 24-bit run words {count[15:0], byte[7:0]} from an input FIFO.
//  Expands each word into 'count' copies of 'byte' and writes them to an 8-bit output FIFO.
//  Sits between the HPS-fed run-word FIFO and the byte FIFO read back through the PIOs.
//  Used to round-trip check the encoder in hardware.
// PARAMETERS
//  BYTE_W   8    width of data symbol
//  COUNT_W  16   width of run-length field; word width = COUNT_W+BYTE_W
// PORTS
//  clk            in   1   system clock; all logic on rising edge
//  reset          in   1   synchronous, active-high reset
//  in_data        in   24  run word from input FIFO (non-showahead: valid 1 cycle after in_read_req)
//  in_empty       in   1   input FIFO empty
//  in_read_req    out  1   pop one word from input FIFO
//  out_full       in   1   output FIFO full
//  out_data       out  8   expanded byte
//  out_write_req  out  1   push out_data into output FIFO this cycle
//  busy           out  1   high while a run is loaded or being emitted
//  run_done       out  1   1-cycle pulse when the last byte of a run is written
//  bytes_out      out  32  total bytes written since reset, wraps at 2^32
// BEHAVIOUR
//  Reset (sync, active-high): state=IDLE; in_read_req=0, out_write_req=0, out_data=0, busy=0, run_done=0, bytes_out=0.
//   Reset mid-run discards the loaded run; the word already popped is lost.
//  Word format: byte = in_data[7:0]; count = in_data[23:8]; count is unsigned, 1..65535.
//  FSM, registered outputs:
//   IDLE:  if !in_empty -> assert in_read_req for exactly 1 cycle, go READ.
//   READ:  wait cycle for FIFO latency; go LOAD.
//   LOAD:  latch byte into out_data and count into remaining.
//          If count==0: treat as padding, no output, no run_done; go IDLE.
//          Else go EMIT.
//   EMIT:  each cycle with !out_full: out_write_req=1, remaining-=1, bytes_out+=1.
//          When remaining==1 and written: pulse run_done, go IDLE.
//          out_full=1: out_write_req=0; hold remaining and out_data (stall, no loss, no duplication).
//  out_write_req is never asserted while out_full=1 in the same cycle.
//   Combinational gating is permitted: out_write_req = emit_reg & ~out_full.
//  in_read_req is never asserted while in_empty=1, and never outside IDLE.
//   At most one word is outstanding.
//  Throughput: 1 byte/cycle in EMIT.
//   Per-run overhead is 3 cycles (IDLE, READ, LOAD).
//   A run of N bytes takes N+3 cycles with no back-pressure.
//  busy=1 in READ, LOAD and EMIT.
//  bytes_out wraps 0xFFFFFFFF -> 0 silently.
//  remaining is COUNT_W bits; count=65535 emits 65535 bytes (no overflow).
// STRUCTURE
//  Package rle_pkg holds:
//   - BYTE_W, COUNT_W and the word width constant
//   - state encoding typedef (IDLE, READ, LOAD, EMIT)
//   - field-extract functions run_byte() and run_count()
//  The encoder shares this package so both ends agree on the word layout.
//  No sub-module: a single FSM plus the remaining and bytes_out counters.
//  FIFOs are external (scfifo in Qsys), not inside this block.
// TESTING
//  1. Word 0x000341 (count 3, 'A') with out_full=0:
//     -> 3 writes of 0x41 on consecutive cycles; run_done pulses once; bytes_out=3.
//  2. Words 0x000142, 0x000000, 0x000243:
//     -> output 42 43 43; no write and no run_done for the zero word; bytes_out=3.
//  3. Count 5 with out_full held high for cycles 2-4 of EMIT:
//     -> exactly 5 writes of the byte; none while full; remaining frozen during stall.
//  4. in_empty=1 for 100 cycles:
//     -> in_read_req and out_write_req stay 0; busy=0.
//  5. Count 0xFFFF:
//     -> 65535 writes; run_done on the last one only.
//  6. Reset asserted on the 2nd EMIT cycle of count 4:
//     -> next cycle all outputs at reset values; then the next FIFO word is decoded normally.
//  Scoreboard: feed encoder output of random byte streams; decoded stream == original.

Source files
------------

// File: rtl/rle_pkg.sv
// ============================================================================
// Module   : rle_pkg
// Purpose  : Shared run-word layout for the RLE encoder/decoder pair.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rle_pkg;

    localparam int BYTE_W  = 8;
    localparam int COUNT_W = 16;
    localparam int WORD_W  = COUNT_W + BYTE_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_LOAD = 2'd2,
        ST_EMIT = 2'd3
    } state_t;

    function automatic logic [BYTE_W-1:0] run_byte(input logic [WORD_W-1:0] word);
        return word[BYTE_W-1:0];
    endfunction

    function automatic logic [COUNT_W-1:0] run_count(input logic [WORD_W-1:0] word);
        return word[WORD_W-1:BYTE_W];
    endfunction

endpackage

`default_nettype wire

// File: rtl/rle_decoder.sv
// ============================================================================
// Module   : rle_decoder
// Purpose  : Expands {count, byte} run words from a FIFO into a byte stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rle_decoder
    import rle_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [WORD_W-1:0]   in_data,
    input  logic                in_empty,
    output logic                in_read_req,
    input  logic                out_full,
    output logic [BYTE_W-1:0]   out_data,
    output logic                out_write_req,
    output logic                busy,
    output logic                run_done,
    output logic [31:0]         bytes_out
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [COUNT_W-1:0]   r_remaining;
    logic [COUNT_W-1:0]   w_remaining_nxt;
    logic [BYTE_W-1:0]    r_out_data;
    logic [BYTE_W-1:0]    w_out_data_nxt;
    logic                 r_in_read_req;
    logic                 w_in_read_req_nxt;
    logic [31:0]          r_bytes_out;
    logic                 w_write;

    // Back-pressure gates the write in the same cycle so nothing is pushed into a full FIFO.
    assign w_write = (r_state == ST_EMIT) && !out_full;

    always_comb begin
        w_state_nxt       = r_state;
        w_remaining_nxt   = r_remaining;
        w_out_data_nxt    = r_out_data;
        w_in_read_req_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!in_empty) begin
                    w_in_read_req_nxt = 1'b1;
                    w_state_nxt       = ST_READ;
                end
            end
            ST_READ: w_state_nxt = ST_LOAD;
            ST_LOAD: begin
                // Zero-count words are padding: latched but never emitted.
                w_out_data_nxt  = run_byte(in_data);
                w_remaining_nxt = run_count(in_data);
                w_state_nxt     = (run_count(in_data) == '0) ? ST_IDLE : ST_EMIT;
            end
            ST_EMIT: begin
                if (w_write) begin
                    w_remaining_nxt = r_remaining - COUNT_W'(1);
                    if (r_remaining == COUNT_W'(1)) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_remaining   <= '0;
            r_out_data    <= '0;
            r_in_read_req <= 1'b0;
            r_bytes_out   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_remaining   <= w_remaining_nxt;
            r_out_data    <= w_out_data_nxt;
            r_in_read_req <= w_in_read_req_nxt;
            if (w_write) begin
                r_bytes_out <= r_bytes_out + 32'd1;
            end
        end
    end

    assign in_read_req   = r_in_read_req;
    assign out_data      = r_out_data;
    assign out_write_req = w_write;
    assign run_done      = w_write && (r_remaining == COUNT_W'(1));
    assign busy          = (r_state != ST_IDLE);
    assign bytes_out     = r_bytes_out;

endmodule

`default_nettype wire

// File: tb/tb_rle_decoder.sv
// ============================================================================
// Module   : tb_rle_decoder
// Purpose  : Self-checking bench for rle_decoder with FIFO models and scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rle_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] in_data;
    logic        in_empty;
    logic        in_read_req;
    logic        out_full;
    logic [7:0]  out_data;
    logic        out_write_req;
    logic        busy;
    logic        run_done;
    logic [31:0] bytes_out;

    always #5 clk = ~clk;

    rle_decoder dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_empty      (in_empty),
        .in_read_req   (in_read_req),
        .out_full      (out_full),
        .out_data      (out_data),
        .out_write_req (out_write_req),
        .busy          (busy),
        .run_done      (run_done),
        .bytes_out     (bytes_out)
    );

    // Non-showahead input FIFO: q updates one edge after the read request.
    logic [23:0] in_mem [0:8191];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic [23:0] fifo_q = '0;
    assign in_data  = fifo_q;
    assign in_empty = (rd_ptr == wr_ptr);

    logic [7:0] got_byte[$];
    int         got_cyc[$];
    int         cyc = 0;
    int         done_cnt = 0;
    int         last_done_cyc = -1;
    int         viol_full = 0;
    int         viol_empty = 0;
    int         viol_done = 0;

    always @(posedge clk) begin
        if (out_write_req) begin
            got_byte.push_back(out_data);
            got_cyc.push_back(cyc);
            if (out_full) viol_full++;
        end
        if (run_done) begin
            done_cnt++;
            last_done_cyc = cyc;
            if (!out_write_req) viol_done++;
        end
        if (in_read_req) begin
            if (rd_ptr == wr_ptr) viol_empty++;
            else begin
                fifo_q <= in_mem[rd_ptr];
                rd_ptr <= rd_ptr + 1;
            end
        end
        cyc++;
    end

    int          checks = 0;
    int          failures = 0;
    logic [31:0] mdl_bytes = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic push(input logic [23:0] w);
        in_mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        repeat (2) @(negedge clk);
        while ((busy || rd_ptr != wr_ptr) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            failures++;
            $display("FAIL %s: idle timeout after %0d cycles", name, budget);
        end
    endtask

    task automatic wait_write(input int budget, input string name);
        int n = 0;
        while (!out_write_req && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            failures++;
            $display("FAIL %s: no write within %0d cycles", name, budget);
        end
    endtask

    typedef struct {
        logic [23:0] word;
        int          exp_n;
        logic [7:0]  exp_byte;
        int          exp_done;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          base;
        int          d0;
        int          k;
        int          nbad;
        int          last;
        logic [7:0]  stream[$];
        logic [23:0] words[$];
        bit          push_done;

        vecs[0] = '{24'h000341, 3,     8'h41, 1};
        vecs[1] = '{24'h000142, 1,     8'h42, 1};
        vecs[2] = '{24'h000000, 0,     8'h00, 0};
        vecs[3] = '{24'h000243, 2,     8'h43, 1};
        vecs[4] = '{24'h0001FF, 1,     8'hFF, 1};
        vecs[5] = '{24'h0010AA, 16,    8'hAA, 1};
        vecs[6] = '{24'hFFFF5A, 65535, 8'h5A, 1};

        reset    = 1'b1;
        out_full = 1'b0;
        repeat (3) @(negedge clk);
        check("reset in_read_req",   {63'd0, in_read_req},   64'd0);
        check("reset out_write_req", {63'd0, out_write_req}, 64'd0);
        check("reset out_data",      {56'd0, out_data},      64'd0);
        check("reset busy",          {63'd0, busy},          64'd0);
        check("reset run_done",      {63'd0, run_done},      64'd0);
        check("reset bytes_out",     {32'd0, bytes_out},     64'd0);
        reset = 1'b0;

        // Empty input: nothing may move.
        nbad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_read_req || out_write_req || busy) nbad++;
        end
        check("idle while empty", nbad, 0);

        for (int i = 0; i < 7; i++) begin
            base = got_byte.size();
            d0   = done_cnt;
            k    = cyc;
            push(vecs[i].word);
            mdl_bytes = mdl_bytes + 32'(vecs[i].exp_n);
            wait_idle(70000, $sformatf("vec%0d", i));
            check($sformatf("vec%0d writes", i), got_byte.size() - base, vecs[i].exp_n);
            nbad = 0;
            for (int j = base; j < got_byte.size(); j++) begin
                if (got_byte[j] !== vecs[i].exp_byte) nbad++;
            end
            check($sformatf("vec%0d bad bytes", i), nbad, 0);
            check($sformatf("vec%0d run_done count", i), done_cnt - d0, vecs[i].exp_done);
            check($sformatf("vec%0d bytes_out", i), bytes_out, mdl_bytes);
            if (vecs[i].exp_n > 0 && got_byte.size() > base) begin
                last = got_byte.size() - 1;
                check($sformatf("vec%0d first write latency", i), got_cyc[base] - k, 3);
                check($sformatf("vec%0d write span", i), got_cyc[last] - got_cyc[base], vecs[i].exp_n - 1);
                check($sformatf("vec%0d run_done on last", i), last_done_cyc, got_cyc[last]);
            end
        end

        // Three words back to back, the middle one padding.
        base = got_byte.size();
        d0   = done_cnt;
        push(24'h000142);
        push(24'h000000);
        push(24'h000243);
        mdl_bytes = mdl_bytes + 32'd3;
        wait_idle(200, "burst");
        check("burst writes", got_byte.size() - base, 3);
        if (got_byte.size() - base == 3) begin
            check("burst byte0", got_byte[base],     8'h42);
            check("burst byte1", got_byte[base + 1], 8'h43);
            check("burst byte2", got_byte[base + 2], 8'h43);
        end
        check("burst run_done count", done_cnt - d0, 2);
        check("burst bytes_out", bytes_out, mdl_bytes);

        // Count 5, out_full high during EMIT cycles 2..4.
        base = got_byte.size();
        push(24'h0005C3);
        mdl_bytes = mdl_bytes + 32'd5;
        wait_write(20, "stall start");
        @(negedge clk);
        out_full = 1'b1;
        #1;
        check("stall write_req low", {63'd0, out_write_req}, 64'd0);
        check("stall data held", {56'd0, out_data}, 64'hC3);
        repeat (3) @(negedge clk);
        out_full = 1'b0;
        wait_idle(100, "stall");
        check("stall writes", got_byte.size() - base, 5);
        if (got_byte.size() - base == 5) begin
            check("stall span", got_cyc[base + 4] - got_cyc[base], 7);
        end
        check("stall bytes_out", bytes_out, mdl_bytes);

        // Reset in the second EMIT cycle, then the next word decodes normally.
        push(24'h000452);
        push(24'h000255);
        wait_write(20, "reset start");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrun reset in_read_req",   {63'd0, in_read_req},   64'd0);
        check("midrun reset out_write_req", {63'd0, out_write_req}, 64'd0);
        check("midrun reset out_data",      {56'd0, out_data},      64'd0);
        check("midrun reset busy",          {63'd0, busy},          64'd0);
        check("midrun reset run_done",      {63'd0, run_done},      64'd0);
        check("midrun reset bytes_out",     {32'd0, bytes_out},     64'd0);
        base      = got_byte.size();
        mdl_bytes = 32'd2;
        wait_idle(100, "after reset");
        check("after reset writes", got_byte.size() - base, 2);
        nbad = 0;
        for (int j = base; j < got_byte.size(); j++) begin
            if (got_byte[j] !== 8'h55) nbad++;
        end
        check("after reset bad bytes", nbad, 0);
        check("after reset bytes_out", bytes_out, mdl_bytes);

        // Random byte streams through a behavioural encoder, decoded under random back-pressure.
        for (int r = 0; r < 40; r++) begin
            logic [7:0] b;
            int         len;
            b   = 8'($urandom);
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(200, 300)) : int'($urandom_range(1, 12));
            for (int j = 0; j < len; j++) stream.push_back(b);
        end
        begin
            int i = 0;
            while (i < stream.size()) begin
                logic [7:0] b;
                int         n;
                b = stream[i];
                n = 0;
                while (i < stream.size() && stream[i] == b && n < 65535) begin
                    n++;
                    i++;
                end
                words.push_back({16'(n), b});
                if ($urandom_range(0, 7) == 0) words.push_back({16'h0000, 8'($urandom)});
            end
        end
        base      = got_byte.size();
        mdl_bytes = mdl_bytes + 32'(stream.size());
        push_done = 1'b0;
        fork
            begin
                foreach (words[j]) begin
                    repeat ($urandom_range(0, 6)) @(negedge clk);
                    push(words[j]);
                end
                push_done = 1'b1;
            end
            begin
                while (!push_done) begin
                    @(negedge clk);
                    out_full = ($urandom_range(0, 3) == 0);
                end
            end
        join
        out_full = 1'b0;
        wait_idle(10000, "random");
        check("random length", got_byte.size() - base, stream.size());
        nbad = 0;
        for (int j = 0; j < stream.size() && base + j < got_byte.size(); j++) begin
            if (got_byte[base + j] !== stream[j]) nbad++;
        end
        check("random stream mismatches", nbad, 0);
        check("random bytes_out", bytes_out, mdl_bytes);

        check("write while full", viol_full, 0);
        check("read while empty", viol_empty, 0);
        check("run_done without write", viol_done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
